serv_mtimer: RTL and testbench

SERV_MTIMER -- requirements
Module: serv_mtimer

---
 rtl/serv_mtimer.sv | 134 +++++++++++++
 tb/tb_serv_mtimer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a single-beat Wishbone-style port.
// Define SERV_MTIMER_PRESCALER_EN to add a 16-bit tick prescaler at adr 4.
module serv_mtimer #(
   parameter RESET_STRATEGY = "MINI"
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_we,
   input  logic [2:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_irq
);

   localparam logic RESET_ALL = (RESET_STRATEGY != "NONE");

   logic        ack_reg;
   logic        irq_reg;
   logic [31:0] rdt_reg;
   logic [31:0] rdt_next;
   logic [31:0] rd_data;
   logic [63:0] mtime_reg;
   logic [63:0] mtime_next;
   logic [63:0] mtimecmp_reg;
   logic [63:0] mtimecmp_next;
   logic [31:0] wmask;
   logic        accept;
   logic        wr_en;
   logic        tick;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wmask
         assign wmask[gi*8 +: 8] = {8{i_wb_sel[gi]}};
      end
   endgenerate

   // The ack cycle and reset both block acceptance.
   assign accept = i_wb_cyc & ~ack_reg & ~i_rst;
   assign wr_en  = accept & i_wb_we;

`ifdef SERV_MTIMER_PRESCALER_EN
   logic [15:0] presc_reg;
   logic [15:0] presc_next;
   logic [15:0] pcnt_reg;
   logic [15:0] pcnt_next;
   logic        presc_wr;

   assign presc_wr = wr_en & (i_wb_adr == 3'd4);
   assign tick     = (pcnt_reg == presc_reg);

   always_comb begin
      presc_next = presc_reg;
      pcnt_next  = tick ? 16'd0 : pcnt_reg + 16'd1;
      if (presc_wr) begin
         presc_next = (presc_reg & ~wmask[15:0]) | (i_wb_dat[15:0] & wmask[15:0]);
         pcnt_next  = 16'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst && RESET_ALL) begin
         presc_reg <= 16'd0;
         pcnt_reg  <= 16'd0;
      end else begin
         presc_reg <= presc_next;
         pcnt_reg  <= pcnt_next;
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      rd_data = 32'd0;
      case (i_wb_adr)
         3'd0:    rd_data = mtime_reg[31:0];
         3'd1:    rd_data = mtime_reg[63:32];
         3'd2:    rd_data = mtimecmp_reg[31:0];
         3'd3:    rd_data = mtimecmp_reg[63:32];
`ifdef SERV_MTIMER_PRESCALER_EN
         3'd4:    rd_data = {16'd0, presc_reg};
`endif
         default: rd_data = 32'd0;
      endcase
   end

   // accept is low during reset, so rdt clears itself there under either strategy.
   assign rdt_next = (accept & ~i_wb_we) ? rd_data : 32'd0;

   always_comb begin
      mtime_next    = mtime_reg + {63'd0, tick};
      mtimecmp_next = mtimecmp_reg;
      if (wr_en) begin
         case (i_wb_adr)
            3'd0: mtime_next = {mtime_reg[63:32],
                                (mtime_reg[31:0] & ~wmask) | (i_wb_dat & wmask)};
            3'd1: mtime_next = {(mtime_reg[63:32] & ~wmask) | (i_wb_dat & wmask),
                                mtime_reg[31:0]};
            3'd2: mtimecmp_next = {mtimecmp_reg[63:32],
                                   (mtimecmp_reg[31:0] & ~wmask) | (i_wb_dat & wmask)};
            3'd3: mtimecmp_next = {(mtimecmp_reg[63:32] & ~wmask) | (i_wb_dat & wmask),
                                   mtimecmp_reg[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      rdt_reg <= rdt_next;
      if (i_rst) begin
         ack_reg <= 1'b0;
         irq_reg <= 1'b0;
      end else begin
         ack_reg <= accept;
         irq_reg <= (mtime_reg >= mtimecmp_reg);
      end
      if (i_rst && RESET_ALL) begin
         mtime_reg    <= 64'd0;
         mtimecmp_reg <= {64{1'b1}};
      end else begin
         mtime_reg    <= mtime_next;
         mtimecmp_reg <= mtimecmp_next;
      end
   end

   assign o_wb_ack = ack_reg;
   assign o_wb_rdt = rdt_reg;
   assign o_irq    = irq_reg;

endmodule

// File: tb/tb_serv_mtimer.sv
// Self-checking bench for serv_mtimer: directed scenarios plus randomized traffic
// compared every cycle against an edge-counting behavioural model.
module tb_serv_mtimer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        we  = 1'b0;
   logic [2:0]  adr = 3'd0;
   logic [31:0] dat = 32'd0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] rdt;
   logic        ack;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   serv_mtimer #(.RESET_STRATEGY("MINI")) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wb_cyc (cyc),
      .i_wb_we  (we),
      .i_wb_adr (adr),
      .i_wb_dat (dat),
      .i_wb_sel (sel),
      .o_wb_rdt (rdt),
      .o_wb_ack (ack),
      .o_irq    (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   // Behavioural model: register file plus an edge counter for tick phase.
   logic        m_valid = 1'b0;
   logic        m_ack, m_irq;
   logic [31:0] m_rdt;
   logic [63:0] m_mtime, m_cmp;
   logic [15:0] m_presc;
   int          ecount = 0;
   int          ph_edge = 0;
   int          ph_p = 0;

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return m_mtime[31:0];
         3'd1: return m_mtime[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
`ifdef SERV_MTIMER_PRESCALER_EN
         3'd4: return {16'd0, m_presc};
`endif
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : p_model
      logic        acc;
      logic        tk;
      logic [63:0] mt;
      ecount <= ecount + 1;
      if (rst) begin
         m_valid <= 1'b1;
         m_ack   <= 1'b0;
         m_rdt   <= 32'd0;
         m_irq   <= 1'b0;
         m_mtime <= 64'd0;
         m_cmp   <= {64{1'b1}};
         m_presc <= 16'd0;
         ph_edge <= ecount;
         ph_p    <= 0;
      end else if (m_valid) begin
         acc = cyc && !m_ack;
`ifdef SERV_MTIMER_PRESCALER_EN
         // a tick lands on every (presc+1)-th edge counted from the last presc write/reset
         tk = (((ecount - ph_edge) % (ph_p + 1)) == 0);
`else
         tk = 1'b1;
`endif
         m_ack <= acc;
         m_irq <= (m_mtime >= m_cmp);
         m_rdt <= (acc && !we) ? model_read(adr) : 32'd0;
         mt = m_mtime + 64'(tk);
         if (acc && we) begin
            case (adr)
               3'd0: mt = {m_mtime[63:32], merge32(m_mtime[31:0], dat, sel)};
               3'd1: mt = {merge32(m_mtime[63:32], dat, sel), m_mtime[31:0]};
               3'd2: m_cmp <= {m_cmp[63:32], merge32(m_cmp[31:0], dat, sel)};
               3'd3: m_cmp <= {merge32(m_cmp[63:32], dat, sel), m_cmp[31:0]};
`ifdef SERV_MTIMER_PRESCALER_EN
               3'd4: begin
                  m_presc <= merge32({16'd0, m_presc}, dat, sel) & 32'h0000_FFFF;
                  ph_edge <= ecount;
                  ph_p    <= int'(merge32({16'd0, m_presc}, dat, sel) & 32'h0000_FFFF);
               end
`endif
               default: ;
            endcase
         end
         m_mtime <= mt;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_ack", 64'(ack), 64'(m_ack));
         check("cyc_rdt", 64'(rdt), 64'(m_rdt));
         check("cyc_irq", 64'(irq), 64'(m_irq));
      end
   end

   // Called at posedge+1; returns at posedge+1 of the ack cycle.
   task automatic xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
      logic prev;
      bit   done;
      prev = ack;
      done = 0;
      cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
      for (int n = 0; n < 8 && !done; n++) begin
         @(posedge clk);
         #1;
         if (ack && !prev) done = 1;
         prev = ack;
      end
      cyc = 1'b0;
      rd  = rdt;
      check("xfer_ack_seen", 64'(done), 64'd1);
      $display("xfer we=%0d adr=%0d dat=%h sel=%b rdt=%h t=%0t", w, a, d, s, rd, $time);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, r0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ack", 64'(ack), 64'd0);
      check("reset_rdt", 64'(rdt), 64'd0);
      check("reset_irq", 64'(irq), 64'd0);
      rst = 1'b0;

      // idle 10 cycles, then read mtime_lo
      repeat (10) @(posedge clk);
      #1;
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r);
      check("idle_mtime_lo", 64'(r), 64'd10);
      check("idle_irq", 64'(irq), 64'd0);
      @(posedge clk);
      #1;
      check("ack_one_cycle", 64'(ack), 64'd0);

      // carry from low into high word
      xfer(1'b1, 3'd0, 32'hFFFF_FFFE, 4'hF, r);
      xfer(1'b1, 3'd1, 32'd0, 4'hF, r);
      xfer(1'b0, 3'd1, 32'd0, 4'hF, r);
      check("carry_hi", 64'(r), 64'd1);
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r);
      check("carry_lo", 64'(r), 64'd2);

      // irq timing against mtimecmp = 20
      xfer(1'b1, 3'd1, 32'd0, 4'hF, r);
      xfer(1'b1, 3'd0, 32'd5, 4'hF, r);
      xfer(1'b1, 3'd2, 32'd20, 4'hF, r);
      xfer(1'b1, 3'd3, 32'd0, 4'hF, r);
      repeat (11) @(posedge clk);
      #1;
      check("irq_not_yet", 64'(irq), 64'd0);
      @(posedge clk);
      #1;
      check("irq_rise", 64'(irq), 64'd1);
      xfer(1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, r);
      check("irq_still_set", 64'(irq), 64'd1);
      @(posedge clk);
      #1;
      check("irq_cleared", 64'(irq), 64'd0);

      // byte-enable write and unmapped read
      xfer(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0010, r);
      xfer(1'b0, 3'd2, 32'd0, 4'hF, r);
      check("sel_cmp_lo", 64'(r), 64'hFFFF_CCFF);
      xfer(1'b0, 3'd6, 32'd0, 4'hF, r);
      check("unmapped_rd", 64'(r), 64'd0);
      check("unmapped_ack", 64'(ack), 64'd1);

      // prescaler / adr 4
`ifdef SERV_MTIMER_PRESCALER_EN
      xfer(1'b1, 3'd4, 32'hFFFF_0003, 4'hF, r);
      xfer(1'b0, 3'd4, 32'd0, 4'hF, r);
      check("presc_rd", 64'(r), 64'd3);
`else
      xfer(1'b0, 3'd4, 32'd0, 4'hF, r);
      check("adr4_rd", 64'(r), 64'd0);
`endif
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r0);
      repeat (15) @(posedge clk);
      #1;
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r);
`ifdef SERV_MTIMER_PRESCALER_EN
      check("tick_rate", 64'(r - r0), 64'd4);
`else
      check("tick_rate", 64'(r - r0), 64'd16);
`endif

      // reset during the ack of a write
      xfer(1'b1, 3'd0, 32'h0000_1234, 4'hF, r);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ack", 64'(ack), 64'd0);
      rst = 1'b0;
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r);
      check("rst_mtime_lo", 64'(r), 64'd0);
      xfer(1'b0, 3'd3, 32'd0, 4'hF, r);
      check("rst_cmp_hi", 64'(r), 64'hFFFF_FFFF);
      xfer(1'b0, 3'd2, 32'd0, 4'hF, r);
      check("rst_cmp_lo", 64'(r), 64'hFFFF_FFFF);

      // 64-bit wrap
      xfer(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, r);
      xfer(1'b1, 3'd0, 32'hFFFF_FFFE, 4'hF, r);
      xfer(1'b0, 3'd0, 32'd0, 4'hF, r);
      check("wrap_lo_max", 64'(r), 64'hFFFF_FFFF);
      xfer(1'b0, 3'd1, 32'd0, 4'hF, r);
      check("wrap_hi_zero", 64'(r), 64'd0);

      // randomized traffic, checked by the per-cycle compare
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         cyc = ($urandom_range(0, 2) != 0);
         we  = 1'($urandom_range(0, 1));
         adr = 3'($urandom_range(0, 7));
         sel = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       dat = $urandom;
            1:       dat = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: dat = 32'($urandom_range(0, 80));
         endcase
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      cyc = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
